// File: rtl/instr_load_ctrl_pkg.sv
// Shared constants, state encoding and job legality check for the instruction loader.
package instr_load_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int PAGE_WIDTH = 11;
  localparam int MEM_WORDS  = 2 ** (PAGE_WIDTH - 1);

  localparam logic REGION_OS   = 1'b1;
  localparam logic REGION_PROC = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } ld_state_e;

  // The sum is one bit wider than the operands so a job running off the end cannot wrap.
  function automatic logic job_legal(input logic [PAGE_WIDTH-1:0] base,
                                     input logic [PAGE_WIDTH-1:0] count);
    logic [PAGE_WIDTH:0] end_excl;
    end_excl = {1'b0, base} + {1'b0, count};
    return (count != '0) && (end_excl <= (PAGE_WIDTH + 1)'(MEM_WORDS));
  endfunction

endpackage

// File: rtl/instr_load_ctrl_if.sv
// Job request, loader source handshake, memory write port and status of the instruction loader.
interface instr_load_ctrl_if;
  import instr_load_ctrl_pkg::*;

  logic                  start;
  logic                  region;
  logic [PAGE_WIDTH-1:0] base_addr;
  logic [PAGE_WIDTH-1:0] word_count;
  logic                  abort;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic                  mem_write_flag;
  logic                  mem_write_os;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [DATA_WIDTH-1:0] checksum;

  // master: job requester / word source side; slave: the load controller
  modport master (
    output start, region, base_addr, word_count, abort, src_valid, src_data,
    input  src_ready, mem_write_flag, mem_write_os, mem_addr, mem_data,
           busy, done, error, checksum
  );

  modport slave (
    input  start, region, base_addr, word_count, abort, src_valid, src_data,
    output src_ready, mem_write_flag, mem_write_os, mem_addr, mem_data,
           busy, done, error, checksum
  );

endinterface

// File: rtl/instr_load_ctrl_ld_write_stage.sv
// Registered memory write port: captures address/data/region on an accepted word and
// strobes write_flag for exactly the following cycle.
module ld_write_stage
  import instr_load_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic                  region,
  input  logic [PAGE_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  flag,
  output logic                  os,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data
);

  logic                  flag_reg;
  logic                  os_reg;
  logic [PAGE_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg <= 1'b0;
      os_reg   <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      flag_reg <= write_en;
      if (write_en) begin
        os_reg   <= (region == REGION_OS);
        addr_reg <= addr;
        data_reg <= data;
      end
    end
  end

  // Memory address bus is wider than a page index; upper bits are tied low.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_addr_ext
    if (gi < PAGE_WIDTH) begin : g_pass
      assign mem_addr[gi] = addr_reg[gi];
    end else begin : g_zero
      assign mem_addr[gi] = 1'b0;
    end
  end

  assign flag     = flag_reg;
  assign os       = os_reg;
  assign mem_data = data_reg;

endmodule

// File: rtl/instr_load_ctrl.sv
// Instruction memory load sequencer: validates a job, pulls words over valid/ready,
// writes them through ld_write_stage and reports done/error/checksum.
module instr_load_ctrl
  import instr_load_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  instr_load_ctrl_if.slave  bus
);

  ld_state_e             state_reg, state_next;
  logic                  region_reg;
  logic [PAGE_WIDTH-1:0] base_reg;
  logic [PAGE_WIDTH-1:0] count_reg;
  logic [PAGE_WIDTH-1:0] index_reg;
  logic [DATA_WIDTH-1:0] checksum_reg;
  logic                  error_reg;
  logic                  done_reg;

  logic                  src_ready_c;
  logic                  busy_c;
  logic                  handshake;
  logic                  last_word;
  logic                  job_ok;
  logic                  accept_job;
  logic                  reject_job;
  logic                  abort_load;
  logic                  write_en;
  logic [PAGE_WIDTH-1:0] wr_addr;

  assign handshake  = bus.src_valid && src_ready_c;
  assign last_word  = (index_reg == (count_reg - PAGE_WIDTH'(1)));
  assign job_ok     = job_legal(bus.base_addr, bus.word_count);
  assign accept_job = (state_reg == ST_IDLE) && bus.start && job_ok;
  assign reject_job = (state_reg == ST_IDLE) && bus.start && !job_ok;
  assign abort_load = (state_reg == ST_LOAD) && bus.abort;
  // A word taken in the same cycle as abort is dropped, not written.
  assign write_en   = handshake && !bus.abort;
  assign wr_addr    = base_reg + index_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (accept_job) state_next = ST_LOAD;
      ST_LOAD: begin
        if (bus.abort)                  state_next = ST_IDLE;
        else if (handshake && last_word) state_next = ST_FLUSH;
      end
      ST_FLUSH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    src_ready_c = 1'b0;
    busy_c      = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        src_ready_c = 1'b1;
        busy_c      = 1'b1;
      end
      ST_FLUSH: busy_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_reg   <= REGION_PROC;
      base_reg     <= '0;
      count_reg    <= '0;
      index_reg    <= '0;
      checksum_reg <= '0;
      error_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      // Rejected jobs still get a done pulse so the requester never waits forever.
      done_reg <= (state_reg == ST_FLUSH) || reject_job;
      if (reject_job) begin
        error_reg <= 1'b1;
      end else if (accept_job) begin
        region_reg   <= bus.region;
        base_reg     <= bus.base_addr;
        count_reg    <= bus.word_count;
        index_reg    <= '0;
        checksum_reg <= '0;
        error_reg    <= 1'b0;
      end else if (abort_load) begin
        error_reg <= 1'b1;
      end else if (handshake) begin
        index_reg    <= index_reg + PAGE_WIDTH'(1);
        checksum_reg <= checksum_reg ^ bus.src_data;
      end
    end
  end

  ld_write_stage u_write_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .write_en (write_en),
    .region   (region_reg),
    .addr     (wr_addr),
    .data     (bus.src_data),
    .flag     (bus.mem_write_flag),
    .os       (bus.mem_write_os),
    .mem_addr (bus.mem_addr),
    .mem_data (bus.mem_data)
  );

  assign bus.src_ready = src_ready_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_reg;
  assign bus.error     = error_reg;
  assign bus.checksum  = checksum_reg;

endmodule
